// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    FINISH,
    DONE
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MOVB = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

endpackage

// File: rtl/alu_seq_ctrl_serial_shifter.sv
// Right-shifting register with parallel load; serves as PISO (ser_out)
// or SIPO (par_out, ser_in enters at the MSB).
module serial_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load has priority over shift.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {ser_in, data_q[WIDTH-1:1]};
    end
  end

  // Register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign par_out = data_q;
  assign ser_out = data_q[0];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer wrapping a bit-serial ALU: accepts a parallel request, clears
// the ALU, shifts A/B out LSB-first over WIDTH cycles, deserializes y and
// returns the parallel result with the final flag.
// Optional feature macro: ALU_SEQ_CHAIN_EN (adds in_chain; A reloads the
// last delivered result).
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             in_chain,
`endif
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             alu_rst_n,
  output logic [2:0]       alu_opcode,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_y,
  input  logic             alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_c,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       opreg_q, opreg_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_c_q, out_c_d;

  logic             accept;
  logic             shift_en;
  logic [WIDTH-1:0] a_load_val;
  logic             a_ser, b_ser;
  logic [WIDTH-1:0] y_par;
  logic [WIDTH-1:0] a_par_unused, b_par_unused;
  logic             y_ser_unused;

  assign in_ready = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign shift_en = (state_q == SHIFT);

`ifdef ALU_SEQ_CHAIN_EN
  logic [WIDTH-1:0] last_y_q, last_y_d;
  logic             out_hs;

  assign out_hs = out_valid_q && out_ready;

  // Track the most recently delivered result; a same-edge handshake counts
  // as delivered so back-to-back chained requests see the fresh value.
  always_comb begin
    last_y_d = last_y_q;
    if (out_hs) begin
      last_y_d = out_y_q;
    end
  end

  // Last-delivered result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_y_q <= '0;
    end else begin
      last_y_q <= last_y_d;
    end
  end

  assign a_load_val = in_chain ? (out_hs ? out_y_q : last_y_q) : in_a;
`else
  assign a_load_val = in_a;
`endif

  serial_shifter #(.WIDTH(WIDTH)) u_a_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (a_load_val),
    .shift    (shift_en),
    .ser_in   (1'b0),
    .par_out  (a_par_unused),
    .ser_out  (a_ser)
  );

  serial_shifter #(.WIDTH(WIDTH)) u_b_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (in_b),
    .shift    (shift_en),
    .ser_in   (1'b0),
    .par_out  (b_par_unused),
    .ser_out  (b_ser)
  );

  serial_shifter #(.WIDTH(WIDTH)) u_y_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (shift_en),
    .ser_in   (alu_y),
    .par_out  (y_par),
    .ser_out  (y_ser_unused)
  );

  // Next-state, counter, opcode and result register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opreg_d     = opreg_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_c_d     = out_c_q;
    if (accept) begin
      opreg_d = in_op;
      cnt_d   = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = FINISH;
      end
      FINISH: begin
        out_valid_d = 1'b1;
        out_y_d     = y_par;
        out_c_d     = alu_c;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? CLEAR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opreg_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_c_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opreg_q     <= opreg_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_c_q     <= out_c_d;
    end
  end

  assign alu_rst_n  = (state_q == SHIFT) || (state_q == FINISH);
  assign alu_opcode = opreg_q;
  assign alu_a      = shift_en && a_ser;
  assign alu_b      = shift_en && b_ser;
  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_c      = out_c_q;
  assign busy       = (state_q == CLEAR) || (state_q == SHIFT) || (state_q == FINISH);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural bit-serial ALU.
// Optional tests compile in with ALU_SEQ_CHAIN_EN.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_chain;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         alu_rst_n;
  logic [2:0]   alu_opcode;
  logic         alu_a, alu_b, alu_y, alu_c;
  logic         out_valid, out_ready;
  logic [W-1:0] out_y;
  logic         out_c;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    bit           chk_c;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
`ifdef ALU_SEQ_CHAIN_EN
    .in_chain   (in_chain),
`endif
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_rst_n  (alu_rst_n),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_c      (alu_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_c      (out_c),
    .busy       (busy)
  );

  // Behavioural bit-serial ALU: y combinational, carry/flag registered.
  logic alu_cq, alu_cn;
  always_comb begin
    alu_y  = 1'b0;
    alu_cn = alu_cq;
    case (alu_opcode)
      OP_ADD:  begin alu_y = alu_a ^ alu_b ^ alu_cq; alu_cn = (alu_a & alu_b) | (alu_cq & (alu_a ^ alu_b)); end
      OP_SUB:  begin alu_y = alu_a ^ alu_b ^ alu_cq; alu_cn = (~alu_a & alu_b) | (~(alu_a ^ alu_b) & alu_cq); end
      OP_OR:   begin alu_y = alu_a | alu_b; alu_cn = alu_cq | alu_y; end
      OP_AND:  begin alu_y = alu_a & alu_b; alu_cn = alu_cq | alu_y; end
      OP_XOR:  begin alu_y = alu_a ^ alu_b; alu_cn = alu_cq | alu_y; end
      OP_MOVB: begin alu_y = alu_b;         alu_cn = alu_cq | alu_y; end
      OP_CMP:  begin alu_y = alu_a;         alu_cn = (alu_a != alu_b) ? alu_a : alu_cq; end
      default: begin alu_y = alu_cq;        alu_cn = alu_a; end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!alu_rst_n) alu_cq <= 1'b0;
    else            alu_cq <= alu_cn;
  end
  assign alu_c = alu_cq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed at the edge following a negedge where
  // out_valid && out_ready; compare it against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got y=0x%0h c=%0b expected no output", out_y, out_c);
        end else begin
          exp_t  e;
          string t;
          e = sb_q.pop_front();
          t = tag_q.pop_front();
          check({t, "_y"}, 32'(out_y), 32'(e.y));
          if (e.chk_c) check({t, "_c"}, 32'(out_c), 32'(e.c));
        end
      end
    end
  end

  // Present a request and wait (bounded) for its accept edge; returns #1
  // after that edge.
  task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic chain, input bit push,
                       input logic [W-1:0] ey, input logic ec, input bit chk_c);
    bit acc = 0;
    bit r;
    if (push) begin
      exp_t e;
      e.y = ey; e.c = ec; e.chk_c = chk_c;
      sb_q.push_back(e);
      tag_q.push_back(tag);
    end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_chain = chain;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) begin
        acc = 1;
        break;
      end
    end
    #1;
    in_valid = 1'b0; in_chain = 1'b0;
    if (!acc) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) check({tag, "_drain_timeout"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_chain = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_y",      32'(out_y),      32'd0);
    check("rst_out_c",      32'(out_c),      32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_rst_n",  32'(alu_rst_n),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // ADD with latency measurement from the accept edge.
    issue("add", OP_ADD, 8'hF0, 8'h20, 1'b0, 1, 8'h10, 1'b1, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 50);
    check("add_latency", 32'(n), 32'd10);
    drain("add");

    // SUB; opcode must be held during the operation.
    issue("sub", OP_SUB, 8'h05, 8'h07, 1'b0, 1, 8'hFE, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("sub_opcode_held", 32'(alu_opcode), 32'(OP_SUB));
    check("sub_busy", 32'(busy), 32'd1);
    drain("sub");

    issue("cmp_gt", OP_CMP, 8'h81, 8'h80, 1'b0, 1, 8'h81, 1'b1, 1);
    drain("cmp_gt");

    // Backpressure, then a back-to-back accept on the releasing edge.
    out_ready = 1'b0;
    issue("cmp_lt", OP_CMP, 8'h80, 8'h81, 1'b0, 1, 8'h80, 1'b0, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_y",        32'(out_y),     32'h80);
      check("bp_c",        32'(out_c),     32'd0);
      check("bp_in_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    issue("and_b2b", OP_AND, 8'hFF, 8'h0F, 1'b0, 1, 8'h0F, 1'b1, 1);
    check("b2b_busy", 32'(busy), 32'd1);
    drain("and_b2b");

    // Reset during the 4th SHIFT cycle aborts with no result.
    issue("abort", OP_ADD, 8'hAA, 8'h55, 1'b0, 0, 8'h00, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_alu_rst_n", 32'(alu_rst_n), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("abort_no_valid", 32'(n), 32'd0);
    issue("add_after_rst", OP_ADD, 8'h01, 8'h01, 1'b0, 1, 8'h02, 1'b0, 1);
    drain("add_after_rst");

`ifdef ALU_SEQ_CHAIN_EN
    issue("chain_seed", OP_ADD, 8'h10, 8'h01, 1'b0, 1, 8'h11, 1'b0, 1);
    drain("chain_seed");
    issue("chain_add", OP_ADD, 8'hAA, 8'h01, 1'b1, 1, 8'h12, 1'b0, 1);
    drain("chain_add");
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
